// File: rtl/fir_band_scheduler_pkg.sv
// Shared types and defaults for the equalizer band scheduler.
package fir_band_scheduler_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    GAP  = 2'd1,
    RUN  = 2'd2,
    FIN  = 2'd3
  } sched_state_t;

  localparam int DEFAULT_TAPS      = 1021;
  localparam int DEFAULT_NUM_BANDS = 5;

  // Index width for a band count, never narrower than one bit.
  function automatic int idx_width(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/fir_band_scheduler_if.sv
// Sample-queue / FIR-band side signals of the band scheduler.
interface fir_band_scheduler_if #(
  parameter int NUM_BANDS = 5
);
  logic                 smpl_vld;
  logic                 q_primed;
  logic [NUM_BANDS-1:0] band_en;
  logic                 clr_ovr;
  logic [NUM_BANDS-1:0] sequencing;
  logic                 rd_clr;
  logic                 rd_inc;
  logic                 busy;
  logic                 done;
  logic                 overrun;

  modport master (
    output smpl_vld, q_primed, band_en, clr_ovr,
    input  sequencing, rd_clr, rd_inc, busy, done, overrun
  );

  modport slave (
    input  smpl_vld, q_primed, band_en, clr_ovr,
    output sequencing, rd_clr, rd_inc, busy, done, overrun
  );
endinterface

// File: rtl/fir_band_scheduler_prio_next_bit.sv
// Finds the lowest set bit of a mask at or above a start index (combinational).
module fir_band_scheduler_prio_next_bit #(
  parameter int N  = 5,
  parameter int IW = 3
) (
  input  logic [N-1:0] mask,
  input  logic [IW:0]  start,
  output logic         found,
  output logic [IW-1:0] idx
);

  // Scan downwards so the lowest qualifying bit is the last one written.
  always_comb begin
    found = 1'b0;
    idx   = {IW{1'b0}};
    for (int i = N - 1; i >= 0; i--) begin
      if (mask[i] && (i >= int'(start))) begin
        found = 1'b1;
        idx   = IW'(i);
      end else begin
        found = found;
        idx   = idx;
      end
    end
  end

endmodule

// File: rtl/fir_band_scheduler.sv
// Time-multiplexes the shared sample-queue read port across the enabled FIR bands
// of one equalizer sample, with a sticky overrun flag for samples arriving while busy.
module fir_band_scheduler
  import fir_band_scheduler_pkg::*;
#(
  parameter int NUM_BANDS = DEFAULT_NUM_BANDS,
  parameter int TAPS      = DEFAULT_TAPS
) (
  input  logic                  clk,
  input  logic                  rst_n,
  fir_band_scheduler_if.slave   bus
);

  localparam int IW = idx_width(NUM_BANDS);
  localparam int TW = $clog2(TAPS);
  localparam logic [TW-1:0]        TAP_LAST = TW'(TAPS - 1);
  localparam logic [NUM_BANDS-1:0] BAND0    = NUM_BANDS'(1);
  localparam logic [IW:0]          IDX_ZERO = {(IW + 1){1'b0}};
  localparam logic [IW:0]          IDX_ONE  = {{IW{1'b0}}, 1'b1};

  sched_state_t         state_r;
  logic [NUM_BANDS-1:0] en_q_r;
  logic [IW-1:0]        band_idx_r;
  logic [TW-1:0]        tap_cnt_r;
  logic [NUM_BANDS-1:0] sequencing_r;
  logic                 rd_clr_r;
  logic                 rd_inc_r;
  logic                 busy_r;
  logic                 done_r;
  logic                 overrun_r;

  logic                 first_found_s;
  logic [IW-1:0]        first_idx_s;
  logic                 next_found_s;
  logic [IW-1:0]        next_idx_s;
  logic [IW:0]          next_start_s;

  assign next_start_s = {1'b0, band_idx_r} + IDX_ONE;

  fir_band_scheduler_prio_next_bit #(.N(NUM_BANDS), .IW(IW)) u_first (
    .mask  (bus.band_en),
    .start (IDX_ZERO),
    .found (first_found_s),
    .idx   (first_idx_s)
  );

  fir_band_scheduler_prio_next_bit #(.N(NUM_BANDS), .IW(IW)) u_next (
    .mask  (en_q_r),
    .start (next_start_s),
    .found (next_found_s),
    .idx   (next_idx_s)
  );

  // Scheduler FSM; outputs are registered alongside the state they belong to.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_r      <= IDLE;
      en_q_r       <= {NUM_BANDS{1'b0}};
      band_idx_r   <= {IW{1'b0}};
      tap_cnt_r    <= {TW{1'b0}};
      sequencing_r <= {NUM_BANDS{1'b0}};
      rd_clr_r     <= 1'b0;
      rd_inc_r     <= 1'b0;
      busy_r       <= 1'b0;
      done_r       <= 1'b0;
    end else begin
      rd_clr_r <= 1'b0;
      done_r   <= 1'b0;
      case (state_r)
        IDLE: begin
          if (bus.smpl_vld && bus.q_primed) begin
            en_q_r     <= bus.band_en;
            band_idx_r <= first_idx_s;
            busy_r     <= 1'b1;
            if (first_found_s) begin
              state_r  <= GAP;
              rd_clr_r <= 1'b1;
            end else begin
              state_r <= FIN;
              done_r  <= 1'b1;
            end
          end else begin
            state_r <= IDLE;
          end
        end
        GAP: begin
          tap_cnt_r    <= {TW{1'b0}};
          sequencing_r <= BAND0 << band_idx_r;
          rd_inc_r     <= 1'b1;
          state_r      <= RUN;
        end
        RUN: begin
          tap_cnt_r <= tap_cnt_r + {{(TW - 1){1'b0}}, 1'b1};
          if (tap_cnt_r == TAP_LAST) begin
            // Dropping sequencing here is what latches the band's result in the FIR.
            sequencing_r <= {NUM_BANDS{1'b0}};
            rd_inc_r     <= 1'b0;
            if (next_found_s) begin
              band_idx_r <= next_idx_s;
              rd_clr_r   <= 1'b1;
              state_r    <= GAP;
            end else begin
              done_r  <= 1'b1;
              state_r <= FIN;
            end
          end else begin
            state_r <= RUN;
          end
        end
        FIN: begin
          busy_r  <= 1'b0;
          state_r <= IDLE;
        end
        default: begin
          sequencing_r <= {NUM_BANDS{1'b0}};
          rd_inc_r     <= 1'b0;
          busy_r       <= 1'b0;
          state_r      <= IDLE;
        end
      endcase
    end
  end

  // Sticky overrun: a sample offered while a run is in flight is dropped; set beats clear.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      overrun_r <= 1'b0;
    end else if (bus.smpl_vld && (state_r != IDLE)) begin
      overrun_r <= 1'b1;
    end else if (bus.clr_ovr) begin
      overrun_r <= 1'b0;
    end else begin
      overrun_r <= overrun_r;
    end
  end

  assign bus.sequencing = sequencing_r;
  assign bus.rd_clr     = rd_clr_r;
  assign bus.rd_inc     = rd_inc_r;
  assign bus.busy       = busy_r;
  assign bus.done       = done_r;
  assign bus.overrun    = overrun_r;

endmodule
